// File: rtl/fa_serial_ctrl_if.sv
// Requester-side bundle for fa_serial_ctrl: operands, start/busy/done
// handshake and the held result.
interface fa_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  // requester drives operands and start, observes status and result
  modport master (
    output start, x, y, ci,
    input  busy, done, s, co
  );

  // sequencer consumes the request and returns status and result
  modport slave (
    input  start, x, y, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/fa_serial_ctrl.sv
// fa_serial_ctrl: bit-serial add sequencer driving one external
// combinational full adder LSB-first over WIDTH cycles.
// Optional feature macro: FA_SERIAL_OVF_EN adds a two's-complement
// overflow output (ovf), updated together with co.
//
// state | meaning
// IDLE  | waiting for start, fa_* held at 0
// RUN   | one operand bit per cycle through the external adder
// DONE  | one-cycle done pulse, start accepted here for back-to-back ops
module fa_serial_ctrl #(
  parameter  int WIDTH = 8,
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  fa_serial_ctrl_if.slave     bus,
  output logic                fa_x,
  output logic                fa_y,
  output logic                fa_ci,
  input  logic                fa_s,
  input  logic                fa_co
`ifdef FA_SERIAL_OVF_EN
  ,
  output logic                ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
`ifdef FA_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // next-state: bit step in RUN, accept overrides in IDLE/DONE
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
    done_d  = 1'b0;
`ifdef FA_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      RUN: begin
        s_d[idx_q] = fa_s;
        carry_d    = fa_co;
        xr_d       = xr_q >> 1;
        yr_d       = yr_q >> 1;
        if (idx_q == IW'(WIDTH - 1)) begin
          co_d    = fa_co;
`ifdef FA_SERIAL_OVF_EN
          // carry_q is the carry into the MSB on the last bit
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      xr_d    = bus.x;
      yr_d    = bus.y;
      carry_d = bus.ci;
      idx_d   = '0;
      s_d     = '0;
      co_d    = 1'b0;
`ifdef FA_SERIAL_OVF_EN
      ovf_d   = 1'b0;
`endif
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
  end

  // state and output registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // adder operands come only from registers, forced low outside RUN
  assign fa_x  = busy_q & xr_q[0];
  assign fa_y  = busy_q & yr_q[0];
  assign fa_ci = busy_q & carry_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
`ifdef FA_SERIAL_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed bench for fa_serial_ctrl with a behavioural full adder.
module tb_fa_serial_ctrl;
  logic clk;
  logic rst;
  logic fa_x, fa_y, fa_ci, fa_s, fa_co;
`ifdef FA_SERIAL_OVF_EN
  logic ovf;
`endif
  int total;
  int bad;

  fa_serial_ctrl_if #(.WIDTH(8)) bus ();

  fa_serial_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .fa_x  (fa_x),
    .fa_y  (fa_y),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co)
`ifdef FA_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  assign fa_s  = fa_x ^ fa_y ^ fa_ci;
  assign fa_co = (fa_x & fa_y) | (fa_x & fa_ci) | (fa_y & fa_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one operation from an idle/done controller; optionally wiggle start/x/y during RUN
  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic civ, input logic junk, input logic [7:0] es,
                        input logic eco, input logic eovf);
    int lat;
    int bcnt;
    bit got;
    @(negedge clk);
    bus.x = xv; bus.y = yv; bus.ci = civ; bus.start = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0; got = 0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({tag, " fa_x"}, {31'd0, fa_x}, {31'd0, xv[0]});
        chk({tag, " fa_y"}, {31'd0, fa_y}, {31'd0, yv[0]});
        chk({tag, " fa_ci"}, {31'd0, fa_ci}, {31'd0, civ});
        bus.start = junk;
        if (junk) begin
          bus.x = 8'h01; bus.y = 8'h01; bus.ci = 1'b0;
        end
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got = 1;
        bus.start = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, 9);
    chk({tag, " busy_cycles"}, bcnt, 8);
    chk({tag, " s"}, {24'd0, bus.s}, {24'd0, es});
    chk({tag, " co"}, {31'd0, bus.co}, {31'd0, eco});
`ifdef FA_SERIAL_OVF_EN
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
    if (eovf) lat = lat;
`endif
    @(negedge clk);
    chk({tag, " done_single"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " s_held"}, {24'd0, bus.s}, {24'd0, es});
    chk({tag, " idle_fa"}, {29'd0, fa_x, fa_y, fa_ci}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcnt;
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst s", {24'd0, bus.s}, 32'd0);
    chk("rst co", {31'd0, bus.co}, 32'd0);
    chk("rst fa", {29'd0, fa_x, fa_y, fa_ci}, 32'd0);
    rst = 1'b0;

    run_op("c1", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("c2", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("c3", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("c4", 8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);

    // reset after three RUN bits
    @(negedge clk);
    bus.x = 8'h07; bus.y = 8'h00; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("c5 partial_s", {24'd0, bus.s}, 32'h07);
    chk("c5 busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("c5 busy", {31'd0, bus.busy}, 32'd0);
    chk("c5 s", {24'd0, bus.s}, 32'd0);
    chk("c5 co", {31'd0, bus.co}, 32'd0);
    chk("c5 fa", {29'd0, fa_x, fa_y, fa_ci}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    chk("c5 no_done", dcnt, 0);
    run_op("c5b", 8'h23, 8'h45, 1'b1, 1'b0, 8'h69, 1'b0, 1'b0);

    // start held high: back-to-back operations
    @(negedge clk);
    bus.x = 8'hAA; bus.y = 8'h55; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1 && k > 0) begin
          chk("c6 s_cleared", {24'd0, bus.s}, 32'd0);
          chk("c6 rerun_busy", {31'd0, bus.busy}, 32'd1);
        end
      end while (!bus.done && lat < 30);
      chk("c6 period", lat, 9);
      chk("c6 s", {24'd0, bus.s}, 32'hFF);
      chk("c6 co", {31'd0, bus.co}, 32'd0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("c6 idle", {30'd0, bus.busy, bus.done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
